sync_data_streamer: RTL and testbench
=====================================

# sync_data_streamer

Avalon-MM slave that buffers 16-bit words written by the Nios II CPU and streams them to a downstream consumer, such as the MNIST classifier input port, over a valid/ready handshake. It replaces the plain PIO-style `sync_data` output register with a FIFO and a transfer sequencer, so software can post bursts without polling per word. It also provides status, overflow and transfer-count registers.

## Interface
- `DATA_W`, 16, stream word width (taken from `writedata[DATA_W-1:0]`).
- `DEPTH`, 16, FIFO depth; must be a power of 2, minimum 2.
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset, asynchronous, active-low.
- `address`  in  2  register select.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe, zero wait states.
- `writedata`  in  32  write data.
- `readdata`  out  32  combinational read mux of `address`; unused bits are 0.
- `out_data`  out  DATA_W  stream word, registered.
- `out_valid`  out  1  stream word valid, registered.
- `out_ready`  in  1  consumer accepts the word.

## Operation
- A write occurs when `chipselect && !write_n`.
- Register map:
  - **0 DATA**
    - Write: push `writedata[15:0]`.
    - If the FIFO is full, the word is dropped and OVF is set (sticky).
    - Read: FIFO head word, or 0 if empty.
  - **1 CTRL**
    - Bit 0 ENABLE (R/W).
    - Bit 1 FLUSH (write 1: empty the FIFO; self-clearing; reads 0).
    - Bit 2 CLR_OVF (write 1 clears OVF; reads 0).
  - **2 STATUS** (read-only)
    - Bits [$clog2(DEPTH):0] level.
    - Bit 8 empty, bit 9 full, bit 10 OVF, bit 11 `out_valid`.
  - **3 COUNT**
    - 32-bit count of completed handshakes (`out_valid && out_ready`).
    - Wraps from 0xFFFFFFFF to 0.
    - Any write clears it to 0.
- Full is evaluated on the pre-cycle level. A push to a full FIFO is dropped even if a pop happens in the same cycle.
- A simultaneous push and pop leaves the level unchanged.
- FSM states:
  - **IDLE**
    - `out_valid`=0.
    - If ENABLE && !empty: pop head into `out_data`, `out_valid`<=1, go to SEND.
  - **SEND**
    - `out_valid`=1; `out_data` is held stable until a handshake.
    - On handshake with ENABLE && !empty: pop the next word and stay in SEND (one word per clock).
    - On handshake otherwise: `out_valid`<=0, go to IDLE.
    - No handshake: hold.
- Clearing ENABLE never retracts a pending `out_valid`. The pending word completes, then the FSM goes to IDLE.
- FLUSH empties the FIFO only; a word already in `out_data` is still delivered. If FLUSH coincides with a handshake, no pop occurs and the FSM goes to IDLE.
- Reset values:
  - `out_data`=0, `out_valid`=0, state IDLE.
  - FIFO empty, ENABLE=0, OVF=0, COUNT=0.
  - `readdata` follows `address` combinationally (e.g. address 2 reads 0x100).

## Timing
- Register writes take effect at the sampling edge.
- Reads are combinational, with zero latency.
- Write-to-stream latency, with ENABLE=1 and the FSM in IDLE:
  - DATA write sampled at edge E; level is 1 after E.
  - Pop at edge E+1; `out_valid` is high after E+1.
- Throughput: one word per clock while `out_ready`=1 and the FIFO is non-empty.
- `out_data` and `out_valid` change only on clock edges and never depend combinationally on `out_ready`.
- COUNT increments at the edge where the handshake is sampled. If a write to COUNT coincides with a handshake, the write wins and COUNT becomes 0.
- If reset asserts mid-transfer, all state clears asynchronously and `out_valid` drops immediately. The pending word is lost and not counted.

## Structure
- Package `sync_data_pkg` holds:
  - Register addresses: `REG_DATA`=0, `REG_CTRL`=1, `REG_STATUS`=2, `REG_COUNT`=3.
  - CTRL and STATUS bit positions.
  - FSM state encoding: IDLE, SEND.
- Sub-module `sync_data_fifo`: synchronous FIFO with parameters DATA_W and DEPTH. It has push, pop, flush, head, level, empty and full ports, and uses pointers with one extra wrap bit.
- The top level contains the register file, read mux, FSM, output register and COUNT.

## Test plan
- **Basic stream:** ENABLE=1, write 0x1234 then 0xABCD, `out_ready`=1.
  - `out_valid` rises 2 clocks after the first write.
  - `out_data` is 0x1234 then 0xABCD on consecutive cycles.
  - COUNT reads 2.
- **Overflow:** ENABLE=0, write 17 words (0..16).
  - STATUS shows level 16, full=1, OVF=1.
  - After ENABLE=1, exactly words 0..15 stream out.
  - CLR_OVF clears OVF to 0.
- **Backpressure:** 3 words queued, `out_ready` low for 5 cycles.
  - `out_data` stays at the first word with `out_valid`=1.
  - Release `out_ready`: the 3 words arrive in order, then `out_valid`=0.
- **Disable and flush mid-stream:** clear ENABLE while `out_valid`=1 with 4 words in the FIFO.
  - The pending word completes, then IDLE.
  - FLUSH: level 0.
  - Re-enable: no further output.
- **Reset mid-transfer:** assert `reset_n` low while `out_valid`=1.
  - `out_valid`=0 and `out_data`=0 immediately.
  - STATUS reads 0x100; COUNT reads 0.
- **COUNT wrap and clear:** force COUNT to 0xFFFFFFFF via a long run or a bench preset, then one handshake: COUNT=0.
  - A write to COUNT in the same cycle as a handshake yields 0.

Source files
------------

// File: rtl/sync_data_pkg.sv
// Shared definitions for the sync_data streamer: register map, CTRL/STATUS
// bit positions and the transfer sequencer state encoding.
package sync_data_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  localparam int CTRL_ENABLE  = 0;
  localparam int CTRL_FLUSH   = 1;
  localparam int CTRL_CLR_OVF = 2;

  localparam int STAT_EMPTY = 8;
  localparam int STAT_FULL  = 9;
  localparam int STAT_OVF   = 10;
  localparam int STAT_VALID = 11;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/sync_data_fifo.sv
// Synchronous FIFO using read/write pointers with one extra wrap bit.
// Flush wins over a same-cycle push or pop.
module sync_data_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        push,
  input  logic [DATA_W-1:0]           push_data,
  input  logic                        pop,
  input  logic                        flush,
  output logic [DATA_W-1:0]           head,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        empty,
  output logic                        full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign level   = wr_ptr - rd_ptr;
  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign head    = mem[rd_ptr[AW-1:0]];
  assign push_ok = push && !full && !flush;
  assign pop_ok  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/sync_data_streamer.sv
// Avalon-MM slave that queues CPU-written words and streams them out over
// valid/ready, with status, sticky overflow and handshake count registers.
//
// state | meaning
// IDLE  | no word presented, waiting for ENABLE and a non-empty FIFO
// SEND  | out_data/out_valid held until the consumer accepts the word
module sync_data_streamer
  import sync_data_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int AW = $clog2(DEPTH);

  logic              wr;
  logic              data_push;
  logic              ctrl_wr;
  logic              count_wr;
  logic              flush;
  logic              handshake;
  logic              enable_q;
  logic              ovf_q;
  logic [31:0]       count_q;
  logic              fifo_pop;
  logic              load;
  logic              valid_d;
  logic [DATA_W-1:0] head;
  logic [AW:0]       level;
  logic              empty;
  logic              full;
  state_t            state_q;
  state_t            state_d;
  logic              unused_wdata;

  assign wr        = chipselect && !write_n;
  assign data_push = wr && (address == REG_DATA);
  assign ctrl_wr   = wr && (address == REG_CTRL);
  assign count_wr  = wr && (address == REG_COUNT);
  assign flush     = ctrl_wr && writedata[CTRL_FLUSH];
  assign handshake = out_valid && out_ready;

  assign unused_wdata = ^writedata[31:DATA_W];

  sync_data_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (data_push),
    .push_data (writedata[DATA_W-1:0]),
    .pop       (fifo_pop),
    .flush     (flush),
    .head      (head),
    .level     (level),
    .empty     (empty),
    .full      (full)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (ctrl_wr) enable_q <= writedata[CTRL_ENABLE];
      // full is the pre-edge level, so a same-cycle pop does not save the word
      if (data_push && full) ovf_q <= 1'b1;
      else if (ctrl_wr && writedata[CTRL_CLR_OVF]) ovf_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (count_wr) begin
      count_q <= '0;
    end else if (handshake) begin
      count_q <= count_q + 32'd1;
    end
  end

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    load     = 1'b0;
    valid_d  = out_valid;
    case (state_q)
      IDLE: begin
        if (enable_q && !empty && !flush) begin
          fifo_pop = 1'b1;
          load     = 1'b1;
          valid_d  = 1'b1;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (handshake) begin
          if (enable_q && !empty && !flush) begin
            fifo_pop = 1'b1;
            load     = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state_q   <= state_d;
      out_valid <= valid_d;
      if (load) out_data <= head;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      REG_DATA:   if (!empty) readdata[DATA_W-1:0] = head;
      REG_CTRL:   readdata[CTRL_ENABLE] = enable_q;
      REG_STATUS: begin
        readdata[AW:0]       = level;
        readdata[STAT_EMPTY] = empty;
        readdata[STAT_FULL]  = full;
        readdata[STAT_OVF]   = ovf_q;
        readdata[STAT_VALID] = out_valid;
      end
      REG_COUNT:  readdata = count_q;
      default:    readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_sync_data_streamer.sv
// Self-checking bench for sync_data_streamer: directed scenarios plus a
// randomized stream compared against an in-order word queue.
module tb_sync_data_streamer;
  import sync_data_pkg::*;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [1:0]        address = 2'd0;
  logic              chipselect = 1'b0;
  logic              write_n = 1'b1;
  logic [31:0]       writedata = '0;
  logic [31:0]       readdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] got[$];
  logic              hold_prev = 1'b0;
  logic [DATA_W-1:0] held_data = '0;

  always #5 clk = ~clk;

  sync_data_streamer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready)
  );

  // Consumer side: record accepted words and require a stalled word to stay put.
  always @(negedge clk) begin
    #1;
    if (reset_n) begin
      if (hold_prev) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== held_data) begin
          n_errors++;
          $display("FAIL hold_stable: valid=%b data=%h, required valid=1 data=%h",
                   out_valid, out_data, held_data);
        end
      end
      if (out_valid && out_ready) got.push_back(out_data);
      hold_prev = out_valid && !out_ready;
      held_data = out_data;
    end else begin
      hold_prev = 1'b0;
    end
  end

  always @(negedge reset_n) hold_prev = 1'b0;

  function automatic logic [31:0] status_word(input int lvl, input bit ovf, input bit vld);
    logic [31:0] s;
    s = 32'(lvl);
    s[8]  = (lvl == 0);
    s[9]  = (lvl == DEPTH);
    s[10] = ovf;
    s[11] = vld;
    return s;
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic test_reset;
    logic [31:0] rd;
    logic [31:0] exp;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: valid=%b data=%h, required 0/0000", out_valid, out_data);
    end
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), rd);
      exp = (a == 2) ? 32'h100 : 32'h0;
      n_checks++;
      if (rd !== exp) begin
        n_errors++;
        $display("FAIL reset_reg%0d: got %h, required %h", a, rd, exp);
      end
    end
  endtask

  task automatic test_basic;
    logic [31:0] rd;
    got.delete();
    out_ready = 1'b1;
    bus_write(REG_COUNT, 32'h0);
    bus_write(REG_CTRL, 32'h1);
    bus_write(REG_DATA, 32'h1234);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_latency_e: valid=%b, required 0", out_valid);
    end
    bus_write(REG_DATA, 32'hABCD);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h1234) begin
      n_errors++;
      $display("FAIL basic_word0: valid=%b data=%h, required 1/1234", out_valid, out_data);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 16'hABCD) begin
      n_errors++;
      $display("FAIL basic_word1: valid=%b data=%h, required 1/abcd", out_valid, out_data);
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL basic_idle: valid=%b, required 0", out_valid);
    end
    bus_read(REG_COUNT, rd);
    n_checks++;
    if (rd !== 32'd2 || got.size() != 2) begin
      n_errors++;
      $display("FAIL basic_count: count=%0d accepted=%0d, required 2/2", rd, got.size());
    end
  endtask

  task automatic test_overflow;
    logic [31:0]       rd;
    logic [DATA_W-1:0] words[$];
    logic [DATA_W-1:0] w;
    out_ready = 1'b0;
    bus_write(REG_CTRL, 32'h0);
    got.delete();
    for (int i = 0; i <= DEPTH; i++) begin
      w = DATA_W'($urandom);
      words.push_back(w);
      bus_write(REG_DATA, {16'h0, w});
    end
    bus_read(REG_STATUS, rd);
    n_checks++;
    if (rd !== status_word(DEPTH, 1'b1, 1'b0)) begin
      n_errors++;
      $display("FAIL ovf_status_full: got %h, required %h", rd, status_word(DEPTH, 1'b1, 1'b0));
    end
    out_ready = 1'b1;
    bus_write(REG_CTRL, 32'h1);
    for (int k = 0; k < 60 && got.size() < DEPTH; k++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_checks++;
    if (got.size() != DEPTH) begin
      n_errors++;
      $display("FAIL ovf_drain_count: got %0d words, required %0d", got.size(), DEPTH);
    end
    for (int i = 0; i < DEPTH && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== words[i]) begin
        n_errors++;
        $display("FAIL ovf_word%0d: got %h, required %h", i, got[i], words[i]);
      end
    end
    bus_read(REG_STATUS, rd);
    n_checks++;
    if (rd !== status_word(0, 1'b1, 1'b0)) begin
      n_errors++;
      $display("FAIL ovf_sticky: got %h, required %h", rd, status_word(0, 1'b1, 1'b0));
    end
    bus_write(REG_CTRL, 32'h5);
    bus_read(REG_STATUS, rd);
    n_checks++;
    if (rd !== status_word(0, 1'b0, 1'b0)) begin
      n_errors++;
      $display("FAIL ovf_clear: got %h, required %h", rd, status_word(0, 1'b0, 1'b0));
    end
  endtask

  task automatic test_backpressure;
    logic [DATA_W-1:0] w[3];
    out_ready = 1'b0;
    bus_write(REG_CTRL, 32'h1);
    got.delete();
    for (int i = 0; i < 3; i++) begin
      w[i] = DATA_W'($urandom);
      bus_write(REG_DATA, {16'h0, w[i]});
    end
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== w[0]) begin
        n_errors++;
        $display("FAIL bp_hold%0d: valid=%b data=%h, required 1/%h", i, out_valid, out_data, w[0]);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== w[i]) begin
        n_errors++;
        $display("FAIL bp_word%0d: valid=%b data=%h, required 1/%h", i, out_valid, out_data, w[i]);
      end
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || got.size() != 3 ||
        (got.size() == 3 && (got[0] !== w[0] || got[1] !== w[1] || got[2] !== w[2]))) begin
      n_errors++;
      $display("FAIL bp_order: valid=%b accepted=%0d, required valid=0 and 3 words in order",
               out_valid, got.size());
    end
  endtask

  task automatic test_disable_flush;
    logic [31:0]       rd;
    logic [DATA_W-1:0] w0;
    logic [DATA_W-1:0] w;
    out_ready = 1'b0;
    bus_write(REG_CTRL, 32'h1);
    got.delete();
    w0 = DATA_W'($urandom);
    bus_write(REG_DATA, {16'h0, w0});
    for (int i = 0; i < 4; i++) begin
      w = DATA_W'($urandom);
      bus_write(REG_DATA, {16'h0, w});
    end
    bus_read(REG_STATUS, rd);
    n_checks++;
    if (rd !== status_word(4, 1'b0, 1'b1)) begin
      n_errors++;
      $display("FAIL df_pre_status: got %h, required %h", rd, status_word(4, 1'b0, 1'b1));
    end
    bus_write(REG_CTRL, 32'h0);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus_read(REG_STATUS, rd);
    n_checks++;
    if (got.size() != 1 || (got.size() == 1 && got[0] !== w0) || rd !== status_word(4, 1'b0, 1'b0)) begin
      n_errors++;
      $display("FAIL df_pending_done: accepted=%0d status=%h, required 1 word (%h) and status %h",
               got.size(), rd, w0, status_word(4, 1'b0, 1'b0));
    end
    bus_write(REG_CTRL, 32'h2);
    bus_read(REG_STATUS, rd);
    n_checks++;
    if (rd !== status_word(0, 1'b0, 1'b0)) begin
      n_errors++;
      $display("FAIL df_flush: got %h, required %h", rd, status_word(0, 1'b0, 1'b0));
    end
    bus_write(REG_CTRL, 32'h1);
    repeat (5) @(negedge clk);
    n_checks++;
    if (got.size() != 1 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL df_reenable: accepted=%0d valid=%b, required 1/0", got.size(), out_valid);
    end
  endtask

  task automatic test_random_stream;
    logic [31:0]       rd;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] w;
    int                sent;
    sent = 0;
    out_ready = 1'b0;
    bus_write(REG_COUNT, 32'h0);
    bus_write(REG_CTRL, 32'h1);
    got.delete();
    for (int cyc = 0; cyc < 300 && sent < 40; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1 && (sent - got.size()) < 8) begin
        w = DATA_W'($urandom);
        exp_q.push_back(w);
        sent++;
        bus_write(REG_DATA, {16'h0, w});
      end else begin
        @(negedge clk);
      end
    end
    out_ready = 1'b1;
    for (int k = 0; k < 100 && got.size() < exp_q.size(); k++) @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (got.size() != exp_q.size()) begin
      n_errors++;
      $display("FAIL rnd_count_words: got %0d words, required %0d", got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      n_checks++;
      if (got[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL rnd_word%0d: got %h, required %h", i, got[i], exp_q[i]);
      end
    end
    bus_read(REG_COUNT, rd);
    n_checks++;
    if (rd !== 32'(exp_q.size())) begin
      n_errors++;
      $display("FAIL rnd_count_reg: got %0d, required %0d", rd, exp_q.size());
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    out_ready = 1'b0;
    bus_write(REG_CTRL, 32'h1);
    bus_write(REG_DATA, 32'h0000_5A5A);
    bus_write(REG_DATA, 32'h0000_0F0F);
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL rstmid_pending: valid=%b, required 1", out_valid);
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      n_errors++;
      $display("FAIL rstmid_async: valid=%b data=%h, required 0/0000", out_valid, out_data);
    end
    bus_read(REG_STATUS, rd);
    n_checks++;
    if (rd !== 32'h100) begin
      n_errors++;
      $display("FAIL rstmid_status: got %h, required 00000100", rd);
    end
    bus_read(REG_COUNT, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_errors++;
      $display("FAIL rstmid_count: got %h, required 0", rd);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_count_wrap;
    logic [31:0]       rd;
    logic [DATA_W-1:0] w;
    out_ready = 1'b1;
    bus_write(REG_CTRL, 32'h1);
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    bus_read(REG_COUNT, rd);
    n_checks++;
    if (rd !== 32'hFFFF_FFFF) begin
      n_errors++;
      $display("FAIL wrap_preset: got %h, required ffffffff", rd);
    end
    w = DATA_W'($urandom);
    bus_write(REG_DATA, {16'h0, w});
    repeat (3) @(negedge clk);
    bus_read(REG_COUNT, rd);
    n_checks++;
    if (rd !== 32'h0) begin
      n_errors++;
      $display("FAIL wrap_to_zero: got %h, required 0", rd);
    end
    out_ready = 1'b0;
    bus_write(REG_DATA, 32'h0000_C3C3);
    @(negedge clk);
    out_ready = 1'b1;
    bus_write(REG_COUNT, 32'hDEAD_BEEF);
    bus_read(REG_COUNT, rd);
    n_checks++;
    if (rd !== 32'h0 || out_valid !== 1'b0) begin
      n_errors++;
      $display("FAIL count_write_wins: count=%h valid=%b, required 0/0", rd, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_backpressure();
    test_disable_flush();
    test_random_stream();
    test_reset_mid();
    test_count_wrap();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
